matrix_op_sequencer: RTL and testbench

//  Sequences one matrix operation from user button events: op select -> source A -> [source B] -> destination.

---
 rtl/matrix_pkg.sv | 31 +++
 rtl/matrix_op_sequencer.sv | 110 +++++++++++
 tb/tb_matrix_op_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix operation sequencer: state encoding,
// op codes and operand-count classification.
package matrix_pkg;

    localparam int OP_W  = 3;
    localparam int REG_W = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_A     = 3'd1,
        GET_B     = 3'd2,
        GET_DST   = 3'd3,
        EXEC      = 3'd4,
        WAIT_DONE = 3'd5
    } seq_state_t;

    localparam logic [OP_W-1:0] OP_ADD       = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB       = 3'd2;
    localparam logic [OP_W-1:0] OP_MUL       = 3'd3;
    localparam logic [OP_W-1:0] OP_TRANSPOSE = 3'd4;
    localparam logic [OP_W-1:0] OP_NEGATE    = 3'd5;

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_TRANSPOSE) || (op == OP_NEGATE);
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_NEGATE);
    endfunction

endpackage

// File: rtl/matrix_op_sequencer.sv
// Collects op, source and destination selections from button events, then runs
// one start/done handshake with the matrix ALU, aborting with err on timeout.
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              op_valid,
    input  logic [OP_W-1:0]   op_code,
    input  logic              is_reg,
    input  logic [2:0]        reg_num,
    input  logic              cancel,
    input  logic              alu_done,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_op,
    output logic [REG_W-1:0]  src_a,
    output logic [REG_W-1:0]  src_b,
    output logic [REG_W-1:0]  dst,
    output logic              busy,
    output logic              err,
    output logic [2:0]        phase
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              is_reg_d;
    logic [CNT_W-1:0]  cnt;
    logic              sel_ok;
    logic [REG_W-1:0]  sel_idx;
    logic              timed_out;
    logic              op_take;

    // reg_num trails the is_reg pulse by one cycle, so it is qualified by is_reg_d.
    assign sel_ok    = is_reg_d && (reg_num != 3'd0);
    assign sel_idx   = reg_num[REG_W-1:0] - REG_W'(1);
    assign timed_out = (cnt == CNT_LAST);
    assign op_take   = op_valid && is_legal(op_code);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            is_reg_d <= 1'b0;
            cnt      <= '0;
            alu_op   <= '0;
            src_a    <= '0;
            src_b    <= '0;
            dst      <= '0;
        end else begin
            state    <= state_nxt;
            is_reg_d <= is_reg;
            case (state)
                IDLE: begin
                    // A new op clears stale operands so src_b reads 0 for unary ops.
                    if (op_take) begin
                        alu_op <= op_code;
                        src_a  <= '0;
                        src_b  <= '0;
                        dst    <= '0;
                    end
                end
                GET_A:     if (!cancel && sel_ok) src_a <= sel_idx;
                GET_B:     if (!cancel && sel_ok) src_b <= sel_idx;
                GET_DST:   if (!cancel && sel_ok) dst   <= sel_idx;
                EXEC:      cnt <= '0;
                WAIT_DONE: cnt <= cnt + CNT_W'(1);
                default:   cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (op_take) state_nxt = GET_A;
            GET_A: begin
                if (cancel)      state_nxt = IDLE;
                else if (sel_ok) state_nxt = is_unary(alu_op) ? GET_DST : GET_B;
            end
            GET_B: begin
                if (cancel)      state_nxt = IDLE;
                else if (sel_ok) state_nxt = GET_DST;
            end
            GET_DST: begin
                if (cancel)      state_nxt = IDLE;
                else if (sel_ok) state_nxt = EXEC;
            end
            EXEC:      state_nxt = WAIT_DONE;
            WAIT_DONE: if (alu_done || timed_out) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // A done arriving on the timeout cycle suppresses the error.
    always_comb begin
        busy      = 1'b0;
        alu_start = 1'b0;
        err       = 1'b0;
        phase     = state;
        busy      = (state != IDLE);
        alu_start = (state == EXEC);
        err       = ((state == IDLE) && op_valid && !is_legal(op_code)) ||
                    ((state == WAIT_DONE) && !alu_done && timed_out);
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer: operand-list model checked every cycle
// plus hand-computed expectations at key points of each scenario.
module tb_matrix_op_sequencer;
    import matrix_pkg::*;

    localparam int TMO = 32;

    logic             clk = 1'b0;
    logic             nrst = 1'b1;
    logic             op_valid = 1'b0;
    logic [OP_W-1:0]  op_code = '0;
    logic             is_reg = 1'b0;
    logic [2:0]       reg_num = '0;
    logic             cancel = 1'b0;
    logic             alu_done = 1'b0;
    logic             alu_start;
    logic [OP_W-1:0]  alu_op;
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
    logic [REG_W-1:0] dst;
    logic             busy;
    logic             err;
    logic [2:0]       phase;

    matrix_op_sequencer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .nrst(nrst), .op_valid(op_valid), .op_code(op_code),
        .is_reg(is_reg), .reg_num(reg_num), .cancel(cancel), .alu_done(alu_done),
        .alu_start(alu_start), .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
        .dst(dst), .busy(busy), .err(err), .phase(phase)
    );

    // clock/reset
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int n_start = 0;
    int n_err = 0;
    int start_cyc = -1;
    int err_cyc = -1;
    int sel_cyc = -1;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a pending list of operand slots (1=A, 2=B, 3=dst) drained by selections.
    int m_mode = 0;
    int m_q[$];
    int m_op = 0;
    int m_a = 0;
    int m_b = 0;
    int m_d = 0;
    int m_wait = 0;
    bit m_isreg = 1'b0;
    bit m_sel;
    int m_idx;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_mode = 0; m_q.delete(); m_op = 0; m_a = 0; m_b = 0; m_d = 0;
            m_wait = 0; m_isreg = 1'b0;
        end else begin
            m_sel = m_isreg && (reg_num != 0);
            m_idx = int'(reg_num) - 1;
            case (m_mode)
                0: if (op_valid && op_code >= 1 && op_code <= 5) begin
                    m_op = int'(op_code); m_a = 0; m_b = 0; m_d = 0;
                    m_q.delete();
                    m_q.push_back(1);
                    if (op_code <= 3) m_q.push_back(2);
                    m_q.push_back(3);
                    m_mode = 1;
                end
                1: if (cancel) begin
                    m_q.delete(); m_mode = 0;
                end else if (m_sel) begin
                    if (m_q[0] == 1) m_a = m_idx;
                    else if (m_q[0] == 2) m_b = m_idx;
                    else m_d = m_idx;
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_mode = 2;
                end
                2: begin m_mode = 3; m_wait = 0; end
                default: if (alu_done || m_wait == TMO - 1) m_mode = 0;
                         else m_wait++;
            endcase
            m_isreg = is_reg;
        end
    end

    function automatic int exp_phase();
        if (m_mode == 0) return 0;
        if (m_mode == 1) return m_q[0];
        if (m_mode == 2) return 4;
        return 5;
    endfunction

    function automatic int exp_err();
        bit illegal = op_valid && !(op_code >= 1 && op_code <= 5);
        return int'((m_mode == 0 && illegal) ||
                    (m_mode == 3 && !alu_done && m_wait == TMO - 1));
    endfunction

    // scoreboard: sampled just before each rising edge, inputs settled
    always @(negedge clk) begin
        #4;
        if (chk_en) begin
            chk("phase", phase, exp_phase());
            chk("busy", busy, int'(m_mode != 0));
            chk("alu_start", alu_start, int'(m_mode == 2));
            chk("err", err, exp_err());
            chk("alu_op", alu_op, m_op);
            chk("src_a", src_a, m_a);
            chk("src_b", src_b, m_b);
            chk("dst", dst, m_d);
        end
        if (alu_start) begin n_start++; start_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; end
    end

    // driver tasks: entered and left on a falling edge
    task automatic do_op(input int op);
        op_valid = 1'b1; op_code = OP_W'(op);
        @(negedge clk);
        op_valid = 1'b0; op_code = '0;
    endtask

    task automatic sel_reg(input int r);
        is_reg = 1'b1;
        @(negedge clk);
        is_reg = 1'b0; reg_num = 3'(r); sel_cyc = cyc;
        @(negedge clk);
        reg_num = '0;
    endtask

    task automatic pulse_done();
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
    endtask

    int s0, e0, hit;

    initial begin
        #1 nrst = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_phase", phase, 0);
        chk("rst_busy", busy, 0);
        chk("rst_src_a", src_a, 0);
        nrst = 1'b1;
        @(negedge clk);

        // ADD r1,r2 -> r3
        do_op(1);
        sel_reg(1);
        chk("add_in_get_b", phase, 2);
        sel_reg(2);
        chk("add_in_get_dst", phase, 3);
        sel_reg(3);
        @(negedge clk);
        chk("add_starts", n_start, 1);
        chk("add_start_lat", start_cyc - sel_cyc, 1);
        chk("add_src_a", src_a, 0);
        chk("add_src_b", src_b, 1);
        chk("add_dst", dst, 2);
        chk("add_op", alu_op, 1);
        repeat (3) @(negedge clk);
        chk("add_one_start", n_start, 1);
        chk("add_busy_wait", busy, 1);
        pulse_done();
        chk("add_busy_after_done", busy, 0);

        // TRANSPOSE r4 -> r1
        s0 = n_start;
        do_op(4);
        sel_reg(4);
        chk("tr_skip_b", phase, 3);
        sel_reg(1);
        @(negedge clk);
        chk("tr_starts", n_start - s0, 1);
        chk("tr_start_lat", start_cyc - sel_cyc, 1);
        chk("tr_src_a", src_a, 3);
        chk("tr_src_b", src_b, 0);
        chk("tr_dst", dst, 0);
        repeat (2) @(negedge clk);
        pulse_done();

        // illegal ops
        e0 = n_err; s0 = n_start;
        do_op(0);
        do_op(7);
        @(negedge clk);
        chk("ill_errs", n_err - e0, 2);
        chk("ill_phase", phase, 0);
        chk("ill_no_start", n_start - s0, 0);

        // cancel in GET_B, then a full ADD
        do_op(1);
        sel_reg(2);
        chk("cx_in_get_b", phase, 2);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cx_phase", phase, 0);
        chk("cx_busy", busy, 0);
        chk("cx_no_err", n_err - e0, 2);
        s0 = n_start;
        do_op(1);
        sel_reg(4);
        sel_reg(4);
        sel_reg(4);
        @(negedge clk);
        chk("cx_add_start", n_start - s0, 1);
        chk("cx_add_a", src_a, 3);
        chk("cx_add_b", src_b, 3);
        chk("cx_add_dst", dst, 3);
        pulse_done();

        // op and accepted selection on the same IDLE cycle: selection dropped
        is_reg = 1'b1;
        @(negedge clk);
        is_reg = 1'b0; reg_num = 3'd2; op_valid = 1'b1; op_code = 3'd1;
        @(negedge clk);
        op_valid = 1'b0; reg_num = '0; op_code = '0;
        chk("sim_phase", phase, 1);
        chk("sim_src_a", src_a, 0);

        // noise: empty selection, op press mid-sequence, reset in WAIT_DONE
        is_reg = 1'b1;
        @(negedge clk);
        is_reg = 1'b0;
        repeat (2) @(negedge clk);
        chk("nz_reg0_phase", phase, 1);
        sel_reg(2);
        sel_reg(3);
        do_op(2);
        chk("nz_op_ignored", phase, 3);
        chk("nz_op_kept", alu_op, 1);
        sel_reg(4);
        @(negedge clk);
        chk("nz_in_wait", phase, 5);
        s0 = n_start;
        nrst = 1'b0;
        #1;
        chk("nz_rst_phase", phase, 0);
        chk("nz_rst_busy", busy, 0);
        chk("nz_rst_op", alu_op, 0);
        chk("nz_rst_dst", dst, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("nz_rst_no_start", n_start - s0, 0);

        // timeout on NEGATE r2 -> r3
        do_op(5);
        sel_reg(2);
        sel_reg(3);
        e0 = n_err;
        for (int i = 0; i < TMO + 20 && n_err == e0; i++) @(negedge clk);
        chk("tmo_err_seen", n_err - e0, 1);
        chk("tmo_err_delay", err_cyc - start_cyc, TMO);
        chk("tmo_phase", phase, 0);
        chk("tmo_src_a", src_a, 1);
        chk("tmo_src_b", src_b, 0);
        chk("tmo_dst", dst, 2);
        s0 = n_start;
        pulse_done();
        chk("late_done_phase", phase, 0);
        chk("late_done_no_err", n_err - e0, 1);

        // done on the timeout cycle wins
        do_op(3);
        sel_reg(1);
        sel_reg(1);
        sel_reg(1);
        e0 = n_err; hit = 0;
        for (int i = 0; i < TMO + 20; i++) begin
            @(negedge clk);
            if (n_start > s0 && cyc == start_cyc + TMO) begin hit = 1; break; end
        end
        chk("dw_window", hit, 1);
        pulse_done();
        chk("dw_no_err", n_err - e0, 0);
        chk("dw_phase", phase, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
